fetch_unit: RTL

- Instruction-fetch stage directly downstream of the PC register.
- Each cycle it offers the current PC to instruction memory over a valid/ready request channel.
- It tracks in-flight requests, buffers in-order responses with their PCs, and presents {pc, instr} to decode over a valid/ready handshake.
- It drives the PC register's stall input: the PC advances only when a fetch request is accepted, or on a flush.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 69 ++++++
 rtl/fetch_unit.sv | 139 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared widths, constants and the decode-facing entry type for the fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN_DEF = 64;
    localparam int unsigned ILEN_DEF = 32;

    localparam logic [ILEN_DEF-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [ILEN_DEF-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO; clear empties it in one cycle and overrides push/pop.
// A push while full is accepted only when a pop frees the slot in the same cycle.
module fetch_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             clear,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q;
    logic [PW-1:0]    rptr_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    // Wrap explicitly so DEPTH=1 (single pointer value) stays legal.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign count   = cnt_q;
    assign rdata   = mem_q[rptr_q];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= wdata;
                wptr_q        <= ptr_inc(wptr_q);
            end
            if (do_pop) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!do_push && do_pop) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited requests to imem, in-order response tagging,
// flush-driven response dropping and a registered output buffer towards decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned ILEN  = ILEN_DEF,
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    output logic            pc_stall,
    input  logic            flush,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [ILEN-1:0] id_instr,
    output logic            rsp_err
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = CW + 2;
    localparam int unsigned EW = XLEN + ILEN;

    logic          run_q;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic          err_q, err_d;

    logic [CW-1:0] occ;
    logic [SW-1:0] pending;
    logic          credit;
    logic          req_fire;
    logic          rsp_drop;
    logic          rsp_take;
    logic          rsp_spur;
    logic          buf_push;
    logic          buf_pop;
    logic          buf_empty;
    logic          buf_full;
    logic [EW-1:0] head;
    logic [XLEN-1:0] tag_pc;
    logic          tag_full;
    logic          tag_empty;
    logic [CW-1:0] tag_cnt;
    logic          unused_fifo_flags;

    function automatic logic [CW-1:0] sat(input logic [SW-1:0] v);
        return (v > SW'(DEPTH)) ? CW'(DEPTH) : v[CW-1:0];
    endfunction

    // Credit uses registered counts only, so id_ready never reaches imem_req_valid.
    assign pending        = SW'(inflight_q) + SW'(drop_cnt_q);
    assign credit         = (pending + SW'(occ)) < SW'(DEPTH);
    assign imem_req_valid = run_q & credit & ~flush;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid & imem_req_ready;
    assign pc_stall       = ~(run_q & (flush | req_fire));

    assign rsp_drop = imem_rsp_valid & (drop_cnt_q != '0);
    assign rsp_take = imem_rsp_valid & (drop_cnt_q == '0) & (inflight_q != '0);
    assign rsp_spur = imem_rsp_valid & (drop_cnt_q == '0) & (inflight_q == '0);
    assign buf_push = rsp_take & ~flush;
    assign buf_pop  = id_valid & id_ready;

    always_comb begin
        inflight_d = inflight_q;
        drop_cnt_d = drop_cnt_q;
        err_d      = err_q | rsp_spur;
        if (flush) begin
            // Everything outstanding becomes a drop; a response arriving now is one of them.
            inflight_d = '0;
            drop_cnt_d = sat(pending - SW'(imem_rsp_valid & (pending != '0)));
        end else begin
            drop_cnt_d = drop_cnt_q - CW'(rsp_drop);
            inflight_d = sat(SW'(inflight_q) + SW'(req_fire) - SW'(rsp_take));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q      <= 1'b0;
            inflight_q <= '0;
            drop_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            run_q      <= 1'b1;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
            err_q      <= err_d;
        end
    end

    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_tag_q (
        .clk   (clk),
        .rst   (rst),
        .push  (req_fire),
        .wdata (pc),
        .pop   (rsp_take),
        .clear (flush),
        .rdata (tag_pc),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_cnt)
    );

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_out_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (buf_push),
        .wdata ({tag_pc, imem_rsp_data}),
        .pop   (buf_pop),
        .clear (flush),
        .rdata (head),
        .full  (buf_full),
        .empty (buf_empty),
        .count (occ)
    );

    assign unused_fifo_flags = ^{tag_full, tag_empty, tag_cnt, buf_full};

    assign id_valid = ~buf_empty;
    assign id_pc    = id_valid ? head[EW-1:ILEN] : '0;
    assign id_instr = id_valid ? head[ILEN-1:0] : '0;
    assign rsp_err  = err_q;

endmodule
